// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        RMW_WR,
        ACK
    } arb_state_e;

    typedef enum logic {
        ID_IF = 1'b0,
        ID_D  = 1'b1
    } arb_id_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane helper: load right-alignment, store lane merge and misalignment detection.
module mem_lane_unit
    import mem_arb_pkg::*;
(
    input  logic [31:0] rd_word_i,
    input  logic [31:0] old_word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o,
    output logic        misaligned_o
);

    always_comb begin
        load_o   = rd_word_i >> {off_i, 3'b000};
        merged_o = old_word_i;
        if (size_i == SZ_B) begin
            merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
        end else if (size_i == SZ_H) begin
            merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
        end else begin
            merged_o = wdata_i;
        end
        misaligned_o = (size_i == 2'b11)
                     | ((size_i == SZ_H) & off_i[0])
                     | ((size_i == SZ_W) & (off_i != 2'b00));
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-read memory port between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration instead of data-over-fetch priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-3:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    arb_state_e        state_q, state_d;
    arb_id_e           id_q, id_d, win;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d, err_q, err_d, grant;
    logic [31:0]       wdata_q, wdata_d, old_q, old_d;
    logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [31:0]       lu_load, lu_merged;
    logic [1:0]        lu_size, lu_off;
    logic              lu_mis;
`ifdef MEM_ARB_RR_EN
    arb_id_e           last_q, last_d;
`endif

    // In IDLE the lane unit checks the live data request; afterwards it works on the latched one.
    assign lu_size = (state_q == IDLE) ? d_size       : size_q;
    assign lu_off  = (state_q == IDLE) ? d_addr[1:0]  : addr_q[1:0];

    mem_lane_unit u_lane (
        .rd_word_i   (mem_rd),
        .old_word_i  (old_q),
        .wdata_i     (wdata_q),
        .size_i      (lu_size),
        .off_i       (lu_off),
        .load_o      (lu_load),
        .merged_o    (lu_merged),
        .misaligned_o(lu_mis)
    );

    always_comb begin
        grant = rst_n & (if_req | d_req);
`ifdef MEM_ARB_RR_EN
        if (d_req && if_req) win = (last_q == ID_D) ? ID_IF : ID_D;
        else                 win = d_req ? ID_D : ID_IF;
`else
        win = d_req ? ID_D : ID_IF;
`endif
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        old_d      = old_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wd     = '0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        d_err      = 1'b0;
        if_rdata   = if_rdata_q;
        d_rdata    = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    id_d = win;
`ifdef MEM_ARB_RR_EN
                    last_d = win;
`endif
                    if (win == ID_D) begin
                        addr_d  = d_addr;
                        size_d  = d_size;
                        we_d    = d_we;
                        wdata_d = d_wdata;
                        err_d   = lu_mis;
                        if (lu_mis) begin
                            state_d = ACK;
                        end else begin
                            mem_addr = d_addr[ADDR_W-1:2];
                            if (!d_we) begin
                                state_d = RD;
                            end else if (d_size == SZ_W) begin
                                mem_we  = 1'b1;
                                mem_wd  = d_wdata;
                                state_d = ACK;
                            end else begin
                                state_d = RMW_RD;
                            end
                        end
                    end else begin
                        addr_d   = if_addr;
                        size_d   = SZ_W;
                        we_d     = 1'b0;
                        err_d    = 1'b0;
                        mem_addr = if_addr[ADDR_W-1:2];
                        state_d  = RD;
                    end
                end
            end
            RD: begin
                mem_addr = addr_q[ADDR_W-1:2];
                state_d  = IDLE;
                if (id_q == ID_IF) begin
                    if_ack     = 1'b1;
                    if_rdata   = mem_rd;
                    if_rdata_d = mem_rd;
                end else begin
                    d_ack     = 1'b1;
                    d_rdata   = lu_load;
                    d_rdata_d = lu_load;
                end
            end
            RMW_RD: begin
                mem_addr = addr_q[ADDR_W-1:2];
                old_d    = mem_rd;
                state_d  = RMW_WR;
            end
            RMW_WR: begin
                mem_addr = addr_q[ADDR_W-1:2];
                mem_we   = we_q;
                mem_wd   = lu_merged;
                state_d  = ACK;
            end
            ACK: begin
                d_ack   = 1'b1;
                d_err   = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            id_q       <= ID_IF;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        wdata_q <= wdata_d;
        old_q   <= old_d;
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= ID_D;
        else        last_q <= last_d;
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a behavioural synchronous-read memory.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [29:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [1024];
    logic        bd_we = 1'b0;
    logic [9:0]  bd_idx = '0;
    logic [31:0] bd_val = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rd;
        logic        err;
        int          lat;
        int          wr;
        logic [31:0] wd;
        logic [29:0] maddr;
    } exp_t;

    exp_t sb[$];

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_ack  (if_ack),
        .if_rdata(if_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_size  (d_size),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_ack   (d_ack),
        .d_rdata (d_rdata),
        .d_err   (d_err),
        .mem_addr(mem_addr),
        .mem_we  (mem_we),
        .mem_wd  (mem_wd),
        .mem_rd  (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we)       mem[bd_idx] <= bd_val;
        else if (mem_we) mem[mem_addr[9:0]] <= mem_wd;
        mem_rd <= mem[mem_addr[9:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] idx, input logic [31:0] v);
        bd_we = 1'b1; bd_idx = idx; bd_val = v;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic chk_rd, input logic err,
                                input int lat, input int wr, input logic [31:0] wd,
                                input logic [29:0] maddr);
        exp_t e;
        e.rdata = rdata; e.chk_rd = chk_rd; e.err = err; e.lat = lat;
        e.wr = wr; e.wd = wd; e.maddr = maddr;
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_acks"}, {28'b0, if_ack, d_ack, d_err, mem_we}, 32'h0);
        chk({tag, "_maddr"}, {2'b0, mem_addr}, 32'h0);
        chk({tag, "_mwd"}, mem_wd, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    endtask

    // Called at posedge+1; the cycle in which the request is raised is the grant cycle.
    task automatic txn(input string tag, input logic is_d, input logic we, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [31:0] wd, input exp_t e);
        exp_t        x;
        int          lat, wr;
        logic [31:0] lastwd;
        logic [29:0] ma0;
        logic        got;
        sb.push_back(e);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_size = sz; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        lat = 0; wr = 0; lastwd = '0; got = 1'b0; ma0 = '0;
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (c == 0) ma0 = mem_addr;
            if (mem_we) begin wr++; lastwd = mem_wd; end
            if (is_d ? d_ack : if_ack) got = 1'b1;
            else begin @(posedge clk); #1; lat++; end
        end
        x = sb.pop_front();
        if (!got) begin
            chk({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            chk({tag, "_maddr0"}, {2'b0, ma0}, {2'b0, x.maddr});
            chk({tag, "_lat"}, 32'(lat), 32'(x.lat));
            chk({tag, "_writes"}, 32'(wr), 32'(x.wr));
            if (x.wr > 0) chk({tag, "_wd"}, lastwd, x.wd);
            if (is_d) chk({tag, "_err"}, {31'b0, d_err}, {31'b0, x.err});
            if (x.chk_rd) chk({tag, "_rdata"}, is_d ? d_rdata : if_rdata, x.rdata);
        end
        @(posedge clk); #1;
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
    endtask

    initial begin
        int          order[$];
        int          ack_cyc[$];
        logic [31:0] dexp[3];
        int          d_left, if_left, who, cyc, exp_who;
        logic        dack_now, iack_now;

        @(posedge clk); #1;
        poke(10'h040, 32'h0000_0013);
        poke(10'h080, 32'hBEEF_1234);
        poke(10'h100, 32'h1234_5678);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");
        @(posedge clk); #1;

        txn("fetch", 1'b1 ^ 1'b1, 1'b0, 2'b10, 32'h100, 32'h0, mk(32'h13, 1, 0, 1, 0, 0, 30'h40));
        txn("lh",   1'b1, 1'b0, 2'b01, 32'h202, 32'h0, mk(32'h0000_BEEF, 1, 0, 1, 0, 0, 30'h80));
        txn("lb",   1'b1, 1'b0, 2'b00, 32'h201, 32'h0, mk(32'h00BE_EF12, 1, 0, 1, 0, 0, 30'h80));

        poke(10'h080, 32'h1122_3344);
        txn("sb",   1'b1, 1'b1, 2'b00, 32'h203, 32'hAB, mk(0, 0, 0, 3, 1, 32'hAB22_3344, 30'h80));
        chk("sb_mem", mem[10'h080], 32'hAB22_3344);
        txn("lw",   1'b1, 1'b0, 2'b10, 32'h200, 32'h0, mk(32'hAB22_3344, 1, 0, 1, 0, 0, 30'h80));

        txn("sw",   1'b1, 1'b1, 2'b10, 32'h300, 32'hCAFE_F00D, mk(0, 0, 0, 1, 1, 32'hCAFE_F00D, 30'hC0));
        chk("sw_mem", mem[10'h0C0], 32'hCAFE_F00D);
        txn("sh",   1'b1, 1'b1, 2'b01, 32'h302, 32'hFFFF_5555, mk(0, 0, 0, 3, 1, 32'h5555_F00D, 30'hC0));
        txn("sb0",  1'b1, 1'b1, 2'b00, 32'h300, 32'h1234_5677, mk(0, 0, 0, 3, 1, 32'h5555_F077, 30'hC0));
        chk("sb0_mem", mem[10'h0C0], 32'h5555_F077);

        txn("mis_lw", 1'b1, 1'b0, 2'b10, 32'h201, 32'h0, mk(0, 0, 1, 1, 0, 0, 30'h0));
        txn("mis_sh", 1'b1, 1'b1, 2'b01, 32'h303, 32'hDEAD_BEEF, mk(0, 0, 1, 1, 0, 0, 30'h0));
        txn("ill_sz", 1'b1, 1'b1, 2'b11, 32'h300, 32'hDEAD_BEEF, mk(0, 0, 1, 1, 0, 0, 30'h0));
        chk("mis_mem", mem[10'h0C0], 32'h5555_F077);
        @(negedge clk);
        chk("hold_d_rdata", d_rdata, 32'hAB22_3344);
        chk("hold_if_rdata", if_rdata, 32'h13);
        @(posedge clk); #1;

        // A fetch right before the contention run makes fetch the last grant.
        txn("fetch2", 1'b0, 1'b0, 2'b10, 32'h100, 32'h0, mk(32'h13, 1, 0, 1, 0, 0, 30'h40));
        poke(10'h081, 32'hA1A1_0001);
        poke(10'h082, 32'hA2A2_0002);
        poke(10'h083, 32'hA3A3_0003);
        dexp[0] = 32'hA1A1_0001; dexp[1] = 32'hA2A2_0002; dexp[2] = 32'hA3A3_0003;
`ifdef MEM_ARB_RR_EN
        order = '{1, 0, 1, 1};
`else
        order = '{1, 1, 1, 0};
`endif
        ack_cyc = '{1, 3, 5, 7};
        d_left = 3; if_left = 1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h204;
        if_req = 1'b1; if_addr = 32'h100;
        cyc = 0;
        while (cyc < 40 && (d_left > 0 || if_left > 0)) begin
            @(negedge clk);
            dack_now = d_ack; iack_now = if_ack;
            if (dack_now || iack_now) begin
                who = dack_now ? 1 : 0;
                exp_who = (order.size() > 0) ? order.pop_front() : -1;
                chk("arb_order", 32'(who), 32'(exp_who));
                if (ack_cyc.size() > 0) chk("arb_cycle", 32'(cyc), 32'(ack_cyc.pop_front()));
                if (dack_now) chk("arb_d_rdata", d_rdata, dexp[3 - d_left]);
                else          chk("arb_if_rdata", if_rdata, 32'h13);
            end
            @(posedge clk); #1;
            cyc++;
            if (dack_now) begin
                d_left--;
                if (d_left == 0) d_req = 1'b0;
                else             d_addr = d_addr + 32'h4;
            end
            if (iack_now) begin
                if_left--;
                if_req = 1'b0;
            end
        end
        if (d_left > 0 || if_left > 0) chk("arb_timeout", 32'h0, 32'h1);
        d_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;

        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h402; d_wdata = 32'h0000_5A5A;
        @(posedge clk); #1;
        rst_n = 1'b0;
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_no_ack", {30'b0, d_ack, mem_we}, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_mid_mem", mem[10'h100], 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single synchronous-read memory port between instruction fetch and the load/store path. It arbitrates between the two requesters and handles byte lanes: loads come back right-aligned, and byte/half stores become read-modify-write sequences. It sits between the fetch stage / `controller` memory signals and the unified memory macro.

## Interface
- `ADDR_W`, 32: requester byte-address width; the memory word index is `ADDR_W-2` bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch byte address; always a word access.
- `if_ack` out 1: one-cycle pulse; `if_rdata` valid in this cycle.
- `if_rdata` out 32: fetched word.
- `d_req` in 1: data request, held until `d_ack`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 00 byte, 01 half, 10 word; 11 is illegal.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 32: store data, right-aligned.
- `d_ack` out 1: one-cycle completion pulse.
- `d_rdata` out 32: load data shifted right by `8*d_addr[1:0]`, not extended (the controller extends it).
- `d_err` out 1: valid with `d_ack`; misaligned access or illegal size.
- `mem_addr` out ADDR_W-2: word index.
- `mem_we` out 1: write strobe; the write commits at the clock edge.
- `mem_wd` out 32: write word.
- `mem_rd` in 32: read word, valid one cycle after the address is presented with `mem_we`=0.

## Operation
- States: IDLE, RD, RMW_RD, RMW_WR, ACK.
- **IDLE grant:**
  - Grant the winning requester.
  - Latch requester ID, address, size, we and wdata.
  - Drive `mem_addr` combinationally from the granted address in the same cycle.
- **Misaligned access:**
  - Misaligned means half with `addr[0]`=1, word with `addr[1:0]`≠0, or `d_size`=11.
  - No memory access is made; go to ACK with `d_err`=1.
- **Transitions:**
  - Load or fetch: IDLE→RD. In RD, `*_ack`=1, rdata comes from `mem_rd`, then return to IDLE.
  - Word store: IDLE with `mem_we`=1 → ACK.
  - Byte/half store: IDLE read → RMW_RD (`mem_rd` valid) → RMW_WR → ACK. RMW_WR is the cycle with `mem_we`=1.
- **RMW_WR write data:** `mem_wd` = `mem_rd` captured in RMW_RD, with lane(s) at `addr[1:0]` replaced by `d_wdata[7:0]` / `[15:0]`.
- **Arbitration:** fixed priority, data over fetch.
- **Requester rule:** `req`, addr, size and wdata stay stable while `req`=1 and unacked. `req` may drop only in the cycle after ack.
- `mem_we`=1 only in the IDLE word-store grant cycle and in RMW_WR.
- `mem_addr`, `mem_wd` = 0 when no access is in progress.
- `if_rdata`, `d_rdata` hold their last value between acks.

## Timing
- **Reset values:** all outputs 0. `rst_n` low forces IDLE immediately.
- **Reset mid-operation:** the transaction is dropped, no ack is issued, and no write is started.
  - An RMW interrupted before RMW_WR leaves memory unchanged.
- **Latency, grant cycle to ack cycle:**
  - Fetch/load/word store: +1.
  - Byte/half store: +3.
  - Misaligned: +1.
- **Back-to-back:** the ack cycle returns to IDLE, so a new grant can come on the next cycle. Peak throughput is one word access per 2 cycles.
- **Simultaneous requests:** both `if_req` and `d_req` high in IDLE → data wins; fetch waits.
  - Fetch is granted in the IDLE cycle following `d_ack`.
- A request that goes high during a busy state is evaluated only in IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration via a 1-bit last-grant register, reset value = data.
  - With both requesting, grant the requester not granted last.
- `MEM_ARB_RR_EN` not defined: fixed data-over-fetch priority; no last-grant register.

## Structure
Package `mem_arb_pkg` contains:
- `mem_size_e` (`SZ_B`, `SZ_H`, `SZ_W`).
- `arb_state_e`.
- `arb_id_e` (`ID_IF`, `ID_D`).

One combinational sub-module, `mem_lane_unit`, performs:
- load right-alignment by offset;
- store lane merge (old word, new data, size, offset → merged word);
- misalignment check.

## Test plan
- **Fetch:** fetch `0x100`, memory word 0x40=`0x00000013`.
  - `mem_addr`=0x40 in cycle 0.
  - `if_ack`=1 with `if_rdata`=`0x00000013` in cycle 1.
- **Byte store RMW:** `sb` `0xAB` to `0x203`, old word `0x11223344`.
  - RMW_WR `mem_wd`=`0xAB223344`.
  - `d_ack` 3 cycles after grant.
  - Word 0x80 reads back `0xAB223344`.
- **Half load:** `lh` at `0x202` from `0xBEEF1234`.
  - `d_rdata`=`0x0000BEEF`, `d_err`=0, latency 1.
- **Misaligned word:** `lw` at `0x201`.
  - `mem_we` stays 0, no read state.
  - `d_ack`=1 and `d_err`=1 in the next cycle.
- **Simultaneous requests:** `if_req` and `d_req` high together for 3 transactions.
  - Default: data, data, data; fetch acks only after `d_req` falls.
  - With `MEM_ARB_RR_EN`: data, fetch, data.
- **Reset in RMW_RD:** drop `rst_n` in RMW_RD of a `sh`.
  - Target word unchanged, no `d_ack`, all outputs 0.
